// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Purpose
//   Raster timing generator for a VGA-style display. A clock divider produces
//   one pixel tick every CLK_DIV clk cycles. On each tick a column counter
//   (countH) advances, and a line counter (countV) advances when the column
//   counter wraps. The sync and visible-area flags are registered from the
//   same next-state values as the counters, so every output presented in a
//   given cycle describes the same (countH, countV) pixel.
//
// Parameters
//   CLK_DIV                    clk cycles per pixel (1..16)
//   H_VIS, H_FP, H_SYNC, H_BP  horizontal visible / front porch / sync / back
//                              porch widths, in pixels
//   V_VIS, V_FP, V_SYNC, V_BP  vertical equivalents, in lines
//
// Ports
//   clk          in   single clock, all state updates on its rising edge
//   rst          in   asynchronous, active-high reset
//   h_sinc       out  horizontal sync, active-low
//   v_sinc       out  vertical sync, active-low
//   countH[10:0] out  current pixel column, 0..H_TOT-1
//   countV[10:0] out  current line, 0..V_TOT-1
//   video_on     out  high while the current pixel is in the visible area
//   pix_tick     out  one-clk pulse; the counters advance at the end of it
//   frame_start  out  one-clk pulse in the first cycle at (0,0) after a
//                     wrap from the last pixel of the frame
// -----------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int CLK_DIV = 2,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic        clk,
   input  logic        rst,
   output logic        h_sinc,
   output logic        v_sinc,
   output logic [10:0] countH,
   output logic [10:0] countV,
   output logic        video_on,
   output logic        pix_tick,
   output logic        frame_start
);

   // ---------------------------------------------------------------------------
   // Derived timing constants, all held at the 11-bit counter width so every
   // compare below is an 11-bit unsigned compare.
   // ---------------------------------------------------------------------------
   localparam int H_TOT_I = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT_I = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOT_I - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOT_I - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_END  = 11'(V_VIS);
   localparam logic [10:0] HS_FIRST   = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_LAST    = 11'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST   = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_LAST    = 11'(V_VIS + V_FP + V_SYNC - 1);

   // A divide-by-1 still needs a 1-bit register to keep the code uniform.
   localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // ---------------------------------------------------------------------------
   // Registers and wires
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0] r_div;
   logic             r_tick;
   logic [10:0]      r_h;
   logic [10:0]      r_v;
   logic             r_hs;
   logic             r_vs;
   logic             r_vid;
   logic             r_fs;

   logic             w_div_last;
   logic             w_h_last;
   logic             w_v_last;
   logic [10:0]      w_h_next;
   logic [10:0]      w_v_next;
   logic             w_hs_next;
   logic             w_vs_next;
   logic             w_vid_next;

   // ---------------------------------------------------------------------------
   // Pixel clock divider.
   // The tick is a registered copy of "divider at its last count", so after
   // reset release the first tick appears on the CLK_DIV-th rising edge and
   // the counters consume it on the following edge. With CLK_DIV = 1 the
   // divider never leaves 0 and the tick stays high from the first edge on.
   // ---------------------------------------------------------------------------
   assign w_div_last = (r_div == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_div_last;
         if (w_div_last) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next raster position. The wrap tests use the last legal value, so a
   // counter can never be loaded with H_TOT or V_TOT.
   // ---------------------------------------------------------------------------
   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);

   always_comb begin
      w_h_next = r_h + 11'd1;
      w_v_next = r_v;
      if (w_h_last) begin
         w_h_next = 11'd0;
         if (w_v_last) begin
            w_v_next = 11'd0;
         end else begin
            w_v_next = r_v + 11'd1;
         end
      end
   end

   // Flags are decoded from the next position so that, once registered, they
   // line up with the counter values loaded on the same edge.
   always_comb begin
      w_hs_next  = ~((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
      w_vs_next  = ~((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
      w_vid_next = (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);
   end

   // ---------------------------------------------------------------------------
   // Raster counters and aligned output flags. Everything holds between
   // ticks; reset abandons the current line/frame at once.
   // Reset state describes pixel (0,0): outside both sync windows and visible.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h   <= 11'd0;
         r_v   <= 11'd0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_vid <= 1'b1;
      end else if (r_tick) begin
         r_h   <= w_h_next;
         r_v   <= w_v_next;
         r_hs  <= w_hs_next;
         r_vs  <= w_vs_next;
         r_vid <= w_vid_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame start marker: set on the edge that wraps (H_TOT-1, V_TOT-1) to
   // (0,0), cleared on the next edge. The counters cannot wrap again on the
   // very next edge, so the pulse is exactly one clk wide even at CLK_DIV = 1.
   // Reset lands on (0,0) without a wrap and therefore never raises it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fs <= 1'b0;
      end else begin
         r_fs <= r_tick & w_h_last & w_v_last;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pix_tick    = r_tick;
   assign countH      = r_h;
   assign countV      = r_v;
   assign h_sinc      = r_hs;
   assign v_sinc      = r_vs;
   assign video_on    = r_vid;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share one clock:
//   u_dut_a  default 640x480 timing, CLK_DIV = 2
//   u_dut_b  reduced 16x12 raster (H 8/2/3/3, V 6/2/2/2), CLK_DIV = 1, so a
//            whole frame (192 ticks) fits in a short run
// Directed steps run in one initial block; outputs are sampled on the falling
// edge, resets are pulsed between edges.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // DUT A: default timing
   // ---------------------------------------------------------------------------
   logic        h_sinc_a, v_sinc_a, video_on_a, pix_tick_a, frame_start_a;
   logic [10:0] countH_a, countV_a;

   vga_sync_gen #(.CLK_DIV(2)) u_dut_a (
      .clk         (clk),
      .rst         (rst_a),
      .h_sinc      (h_sinc_a),
      .v_sinc      (v_sinc_a),
      .countH      (countH_a),
      .countV      (countV_a),
      .video_on    (video_on_a),
      .pix_tick    (pix_tick_a),
      .frame_start (frame_start_a)
   );

   // ---------------------------------------------------------------------------
   // DUT B: small raster, divide-by-1
   // ---------------------------------------------------------------------------
   logic        h_sinc_b, v_sinc_b, video_on_b, pix_tick_b, frame_start_b;
   logic [10:0] countH_b, countV_b;

   vga_sync_gen #(
      .CLK_DIV (1),
      .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_VIS (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst_b),
      .h_sinc      (h_sinc_b),
      .v_sinc      (v_sinc_b),
      .countH      (countH_b),
      .countV      (countV_b),
      .video_on    (video_on_b),
      .pix_tick    (pix_tick_b),
      .frame_start (frame_start_b)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int          checks = 0;
   int          errors = 0;
   logic [10:0] exp_q[$];

   int          n, cyc, per;
   int          bad_v, v_steps;
   int          prev_h, prev_v, ph, pv;
   int          vs_low, vs_min, vs_max, hs_low, vid_cnt, vid_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // All reset values: (0,0), both syncs inactive, visible, no tick, no frame.
   task automatic chk_rst(input string tag, input logic hs, input logic vs, input logic vid,
                          input logic tick, input logic fs, input logic [10:0] h,
                          input logic [10:0] v);
      chk({tag, "_h_sinc"},      hs,   1);
      chk({tag, "_v_sinc"},      vs,   1);
      chk({tag, "_video_on"},    vid,  1);
      chk({tag, "_pix_tick"},    tick, 0);
      chk({tag, "_frame_start"}, fs,   0);
      chk({tag, "_countH"},      h,    0);
      chk({tag, "_countV"},      v,    0);
   endtask

   // Driver helpers: advance falling edges until DUT A / DUT B reach a position.
   task automatic wait_h_a(input logic [10:0] h, input string tag);
      int k;
      k = 0;
      while (countH_a !== h && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_reached"}, countH_a, h);
   endtask

   task automatic wait_hv_a(input logic [10:0] h, input logic [10:0] v, input int budget,
                            input string tag);
      int k;
      k = 0;
      while (!(countH_a === h && countV_a === v) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_reached"}, (countH_a === h && countV_a === v), 1);
   endtask

   task automatic wait_hv_b(input logic [10:0] h, input logic [10:0] v, input int budget,
                            input string tag);
      int k;
      k = 0;
      while (!(countH_b === h && countV_b === v) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_reached"}, (countH_b === h && countV_b === v), 1);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state of both instances (B has CLK_DIV=1: tick must still be 0).
      chk_rst("rst_a", h_sinc_a, v_sinc_a, video_on_a, pix_tick_a, frame_start_a,
              countH_a, countV_a);
      chk_rst("rst_b", h_sinc_b, v_sinc_b, video_on_b, pix_tick_b, frame_start_b,
              countH_b, countV_b);

      // Tick rate, CLK_DIV=2: tick on every 2nd edge; countH 0,1,2 after 2,4,6.
      rst_a = 1'b0;
      exp_q = '{11'd0, 11'd0, 11'd1, 11'd1, 11'd2, 11'd2};
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("tick_rate_pix_tick_edge%0d", k), pix_tick_a, (k % 2 == 0));
         chk($sformatf("tick_rate_countH_edge%0d", k), countH_a, exp_q.pop_front());
      end

      // Horizontal sync and blanking edges on line 0.
      wait_h_a(11'd639, "h639");
      chk("h639_video_on", video_on_a, 1);
      chk("h639_h_sinc",   h_sinc_a,   1);
      wait_h_a(11'd640, "h640");
      chk("h640_video_on", video_on_a, 0);
      wait_h_a(11'd655, "h655");
      chk("h655_h_sinc",   h_sinc_a,   1);
      wait_h_a(11'd656, "h656");
      chk("h656_h_sinc",   h_sinc_a,   0);
      wait_h_a(11'd751, "h751");
      chk("h751_h_sinc",   h_sinc_a,   0);
      wait_h_a(11'd752, "h752");
      chk("h752_h_sinc",   h_sinc_a,   1);
      chk("h752_v_sinc",   v_sinc_a,   1);
      chk("h752_countV",   countV_a,   0);

      // Line wrap: countV may only change on the 799 -> 0 column wrap.
      bad_v   = 0;
      v_steps = 0;
      prev_h  = int'(countH_a);
      prev_v  = int'(countV_a);
      n       = 0;
      while (!(countH_a === 11'd799 && countV_a === 11'd10) && n < 20000) begin
         @(negedge clk);
         n++;
         if (int'(countV_a) != prev_v) begin
            v_steps++;
            if (!(prev_h == 799 && countH_a === 11'd0 && int'(countV_a) == prev_v + 1)) bad_v++;
         end
         prev_h = int'(countH_a);
         prev_v = int'(countV_a);
      end
      chk("line_799_10_reached", (countH_a === 11'd799 && countV_a === 11'd10), 1);
      chk("line_v_changes_off_wrap", bad_v, 0);
      chk("line_v_steps", v_steps, 10);
      n = 0;
      while (countH_a === 11'd799 && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("line_wrap_countH", countH_a, 0);
      chk("line_wrap_countV", countV_a, 11);

      // Mid-frame reset on A, asserted between edges.
      wait_hv_a(11'd700, 11'd11, 3000, "mid_a");
      chk("mid_a_h_sinc_low",   h_sinc_a,   0);
      chk("mid_a_video_off",    video_on_a, 0);
      #2 rst_a = 1'b1;
      #1;
      chk_rst("mid_a_async", h_sinc_a, v_sinc_a, video_on_a, pix_tick_a, frame_start_a,
              countH_a, countV_a);
      @(negedge clk);
      chk_rst("mid_a_held", h_sinc_a, v_sinc_a, video_on_a, pix_tick_a, frame_start_a,
              countH_a, countV_a);
      rst_a = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("mid_a_restart_tick_edge%0d", k), pix_tick_a, (k == 2));
         chk($sformatf("mid_a_restart_countH_edge%0d", k), countH_a, (k == 3) ? 1 : 0);
         chk($sformatf("mid_a_restart_countV_edge%0d", k), countV_a, 0);
      end
      chk("a_no_frame_start", frame_start_a, 0);

      // DUT B, CLK_DIV=1: tick high from the first edge, counting from the second.
      rst_b = 1'b0;
      #1;
      chk("b_release_tick", pix_tick_b, 0);
      @(negedge clk);
      chk("b_edge1_tick",   pix_tick_b, 1);
      chk("b_edge1_countH", countH_b,   0);
      @(negedge clk);
      chk("b_edge2_tick",   pix_tick_b, 1);
      chk("b_edge2_countH", countH_b,   1);
      cyc = 2;

      // First frame_start only after a full 192-tick frame (tick 192 = edge 193).
      ph = int'(countH_b);
      pv = int'(countV_b);
      while (frame_start_b !== 1'b1 && cyc < 600) begin
         ph = int'(countH_b);
         pv = int'(countV_b);
         @(negedge clk);
         cyc++;
      end
      chk("b_first_frame_edge", cyc, 193);
      chk("b_wrap_from_h", ph, 15);
      chk("b_wrap_from_v", pv, 11);
      chk("b_wrap_countH", countH_b, 0);
      chk("b_wrap_countV", countV_b, 0);

      // One full frame: period, one-clk pulse width, sync and visible coverage.
      per     = 0;
      vs_low  = 0;
      vs_min  = 2047;
      vs_max  = 0;
      hs_low  = 0;
      vid_cnt = 0;
      vid_bad = 0;
      do begin
         @(negedge clk);
         per++;
         if (v_sinc_b === 1'b0) begin
            vs_low++;
            if (int'(countV_b) < vs_min) vs_min = int'(countV_b);
            if (int'(countV_b) > vs_max) vs_max = int'(countV_b);
         end
         if (h_sinc_b === 1'b0) hs_low++;
         if (video_on_b === 1'b1) begin
            vid_cnt++;
            if (countV_b >= 11'd6 || countH_b >= 11'd8) vid_bad++;
         end
      end while (frame_start_b !== 1'b1 && per < 600);
      chk("b_frame_period", per, 192);
      chk("b_vsync_low_ticks", vs_low, 32);
      chk("b_vsync_first_line", vs_min, 8);
      chk("b_vsync_last_line", vs_max, 9);
      chk("b_hsync_low_ticks", hs_low, 36);
      chk("b_video_on_ticks", vid_cnt, 48);
      chk("b_video_on_outside", vid_bad, 0);
      @(negedge clk);
      chk("b_frame_start_width", frame_start_b, 0);

      // Mid-frame reset on B inside both sync windows.
      wait_hv_b(11'd11, 11'd8, 300, "mid_b");
      chk("mid_b_h_sinc_low", h_sinc_b,   0);
      chk("mid_b_v_sinc_low", v_sinc_b,   0);
      chk("mid_b_video_off",  video_on_b, 0);
      #2 rst_b = 1'b1;
      #1;
      chk_rst("mid_b_async", h_sinc_b, v_sinc_b, video_on_b, pix_tick_b, frame_start_b,
              countH_b, countV_b);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("mid_b_release_tick", pix_tick_b, 0);
      @(negedge clk);
      chk("mid_b_edge1_tick",   pix_tick_b, 1);
      chk("mid_b_edge1_countH", countH_b,   0);
      @(negedge clk);
      chk("mid_b_edge2_countH", countH_b,   1);
      chk("mid_b_edge2_countV", countV_b,   0);
      chk("mid_b_no_frame",     frame_start_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (legal range 1..16).
REQ-002 SHALL have parameters H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal visible, front porch, sync and back porch widths, in pixels.
REQ-003 SHALL have parameters V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33: vertical visible, front porch, sync and back porch widths, in lines.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port h_sinc, output, 1 bit: horizontal sync, active-low.
REQ-007 SHALL have port v_sinc, output, 1 bit: vertical sync, active-low.
REQ-008 SHALL have port countH, output, 11 bits: current pixel column, 0..H_TOT-1.
REQ-009 SHALL have port countV, output, 11 bits: current line, 0..V_TOT-1.
REQ-010 SHALL have port video_on, output, 1 bit: high when the current pixel is in the visible area.
REQ-011 SHALL have port pix_tick, output, 1 bit: one-clk pulse on the cycle in which the counters advance.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clk pulse marking the wrap to pixel (0,0).

Function
REQ-013 SHALL define H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800 by default) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
REQ-014 SHALL keep a divider counter that counts 0..CLK_DIV-1 and wraps to 0.
REQ-015 SHALL assert pix_tick in the cycle where the divider equals CLK_DIV-1; with CLK_DIV=1, pix_tick SHALL be constantly high after reset.
REQ-016 SHALL advance countH by 1 on each cycle where pix_tick is high; at H_TOT-1, countH SHALL wrap to 0 on the tick.
REQ-017 SHALL advance countV by 1 only on the tick where countH wraps; at V_TOT-1, countV SHALL wrap to 0 on that tick.
REQ-018 SHALL hold countH and countV unchanged on cycles where pix_tick is low.
REQ-019 SHALL register h_sinc, v_sinc and video_on so that they always correspond to the countH/countV values presented in the same cycle, with zero skew between outputs.
REQ-020 SHALL drive h_sinc low iff H_VIS+H_FP <= countH <= H_VIS+H_FP+H_SYNC-1 (656..751 by default).
REQ-021 SHALL drive v_sinc low iff V_VIS+V_FP <= countV <= V_VIS+V_FP+V_SYNC-1 (490..491 by default), independent of countH.
REQ-022 SHALL drive video_on high iff countH < H_VIS and countV < V_VIS.
REQ-023 SHALL assert frame_start for exactly one clk: the first cycle in which countH=0 and countV=0 following a wrap from (H_TOT-1, V_TOT-1).
REQ-024 SHALL never let a counter reach H_TOT or V_TOT; all compares SHALL be done at 11-bit width with no overflow.

Reset
REQ-025 SHALL, while rst is high, force divider=0, countH=0, countV=0, h_sinc=1, v_sinc=1, video_on=1, pix_tick=0 and frame_start=0, asynchronously and regardless of clk.
REQ-026 SHALL, on a reset asserted mid-frame, abandon the frame immediately, with no completion of the current line or frame.
REQ-027 SHALL, after rst deasserts, produce its first pix_tick on the CLK_DIV-th rising clk edge.
REQ-028 SHALL NOT produce a frame_start pulse on reset release; the first pulse SHALL come only from the first full-frame wrap.

Verification
REQ-029 SHALL verify the tick rate: CLK_DIV=2, release reset -> pix_tick every 2nd clk; countH reaches 0,1,2 after 2,4,6 clks.
REQ-030 SHALL verify horizontal sync: defaults -> h_sinc falls in the cycle where countH becomes 656, rises where it becomes 752, and video_on falls where countH becomes 640.
REQ-031 SHALL verify line wrap: countH=799 with countV=10, on the next tick -> countH=0, countV=11; countV unchanged at all other ticks.
REQ-032 SHALL verify vertical sync: v_sinc is low for exactly 2x800 ticks, covering lines 490..491; video_on is low for every countV >= 480.
REQ-033 SHALL verify frame wrap: (799,524) plus one tick -> (0,0) with a single-clk frame_start; the frame period is exactly 420000 ticks.
REQ-034 SHALL verify reset mid-operation: rst pulsed at countH=700, countV=300, between clk edges -> outputs immediately take reset values, then the count restarts from 0; repeat with CLK_DIV=1.
